unary_add_1_14: RTL and testbench
=================================

Name: unary_add_1_14

Overview:
- Unary (pulse-count) accumulator with a 14-bit internal count.
- Write mode: each enabled cycle adds the 1-bit inputs A and B (0, 1 or 2) into the count.
- Read mode: the count is drained as a unary bitstream on dout, one 1 per cycle until it reaches zero.
- Used as a stochastic/unary-computing accumulate-and-replay element between pulse producers and pulse consumers.

Parameters:
- WIDTH, 14, bit width of the internal count register; wrap modulus is 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  asynchronous active-high reset
- A  input  1  unary input pulse, adds 1 when high in write mode
- B  input  1  unary input pulse, adds 1 when high in write mode
- en  input  1  global enable; when low, all state holds
- read_or_write  input  1  0 = write (accumulate), 1 = read (drain)
- dout  output  1  registered unary output stream
- C  output  1  sticky carry/overflow flag

Behaviour:
- Internal register is named count, WIDTH bits; the bench probes it hierarchically as count.
- Reset (rst=1, asynchronous): count=0, dout=0, C=0; they stay there while rst is high.
- en=0: count, dout and C hold their values; A, B and read_or_write are ignored.
- Write mode (en=1, read_or_write=0), per rising edge:
  - sum = count + A + B, computed at WIDTH+1 bits.
  - count <= sum[WIDTH-1:0], i.e. wraps modulo 2^WIDTH.
  - If sum[WIDTH]=1, C <= 1.
  - dout <= 0.
- Read mode (en=1, read_or_write=1), per rising edge:
  - If count != 0: dout <= 1 and count <= count-1.
  - If count == 0: dout <= 0 and count holds; no underflow.
  - A and B are ignored.
- Latency: dout reflects the count value present before the edge; it is high in the cycle after each decrementing edge. A stored count N yields exactly N consecutive dout=1 cycles, then dout=0.
- C is sticky: once set it is cleared only by rst. Mode switches and en do not clear it.
- Mode switch takes effect at the next edge with no flush cycle.
  - Write to read: draining starts from the current count.
  - Read to write: accumulation resumes from the partially drained count.
- A=B=1 at count = 2^WIDTH-1: count wraps to 1 and C sets.
- A=B=1 at count = 2^WIDTH-2: count wraps to 0 and C sets.
- rst asserted mid-drain aborts immediately: dout=0, count=0.

Optional Feature:
- Macro: UNARY_ADD_SATURATE_EN.
- When defined:
  - Write-mode overflow clamps count at 2^WIDTH-1 instead of wrapping.
  - C still sets on any attempted overflow.
  - Subsequent adds keep count at max.
- When undefined: wrap-around behaviour as specified in Behaviour (the default).

Test Plan:
- Reset: assert rst mid-run with count nonzero -> count=0, dout=0, C=0 immediately, without waiting for a clock edge.
- Basic accumulate: en=1, write mode; A=1,B=0 for 3 cycles, then A=1,B=1 for 2 cycles -> count=7, C=0, dout=0 throughout.
- Overflow wrap: en=1, write mode; A=B=1 on 8193 sampled edges, alternating with idle cycles -> count hits 16384 mod 2^14 = 0 with C=1; final count=2, C stays 1.
- Drain: continue the overflow case with read_or_write=1 for 20 cycles -> dout=1 for exactly 2 cycles then 0, count=0, C still 1.
- Enable gating: count=5, en=0, A=B=1 and toggle read_or_write for 10 cycles -> count=5, dout and C unchanged.
- Mode interleave: count=4, read for 2 cycles (count=2, two dout=1), write with A=1,B=1 for 1 cycle -> count=4. Read again -> 4 dout=1 cycles. With UNARY_ADD_SATURATE_EN defined, the overflow test instead ends with count=16383, C=1.

Source files
------------

// File: rtl/unary_add_1_14.sv
// Unary pulse-count accumulator: adds A+B in write mode, drains one pulse per cycle in read mode.
// Define UNARY_ADD_SATURATE_EN to clamp the count at its maximum on overflow instead of wrapping.
module unary_add_1_14 #(
  parameter int WIDTH = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic en,
  input  logic read_or_write,
  output logic dout,
  output logic C
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZX  = '0;

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH:0]   sum;
  logic             dout_nx;
  logic             c_nx;

  always_comb begin
    count_nx = count;
    dout_nx  = dout;
    c_nx     = C;
    sum      = {1'b0, count}
             + {ZX[WIDTH:1], A}
             + {ZX[WIDTH:1], B};
    if (en) begin
      if (read_or_write) begin
        // drain never underflows; an empty count just idles low
        if (count != '0) begin
          dout_nx  = 1'b1;
          count_nx = count - ONE;
        end else begin
          dout_nx  = 1'b0;
        end
      end else begin
        dout_nx  = 1'b0;
        count_nx = sum[WIDTH-1:0];
        if (sum[WIDTH]) begin
          c_nx = 1'b1;
`ifdef UNARY_ADD_SATURATE_EN
          count_nx = '1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dout  <= 1'b0;
      C     <= 1'b0;
    end else begin
      count <= count_nx;
      dout  <= dout_nx;
      C     <= c_nx;
    end
  end

endmodule

// File: tb/tb_unary_add_1_14.sv
// Scoreboard bench for unary_add_1_14: driver pushes expected state, monitor
// pops and compares one cycle later.
module tb_unary_add_1_14;

  logic clk = 1'b0;
  logic rst, A, B, en, read_or_write;
  logic dout, C;

  typedef struct {
    logic        d;
    logic [13:0] cnt;
    logic        c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   mcount;
  bit   mc, md;
  int   ones;

  always #5 clk = ~clk;

  unary_add_1_14 dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .en(en),
    .read_or_write(read_or_write), .dout(dout), .C(C)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_dout", int'(dout), int'(e.d));
      chk("sb_count", int'(dut.count), int'(e.cnt));
      chk("sb_C", int'(C), int'(e.c));
    end
  end

  // called at a negedge; leaves en low at the following negedge
  task automatic step(input bit e, input bit rw, input bit a, input bit b);
    int s;
    exp_t x;
    en = e; read_or_write = rw; A = a; B = b;
    if (e) begin
      if (rw) begin
        if (mcount != 0) begin
          md = 1'b1;
          mcount = mcount - 1;
        end else begin
          md = 1'b0;
        end
      end else begin
        md = 1'b0;
        s = mcount + int'(a) + int'(b);
        if (s >= 16384) begin
          mc = 1'b1;
`ifdef UNARY_ADD_SATURATE_EN
          s = 16383;
`else
          s = s - 16384;
`endif
        end
        mcount = s;
      end
    end
    x.d = md; x.cnt = 14'(mcount); x.c = mc;
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    if (dout) ones++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mcount = 0; mc = 1'b0; md = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ones = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; A = 1'b0; B = 1'b0; read_or_write = 1'b0;
    mcount = 0; mc = 1'b0; md = 1'b0; ones = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", int'(dut.count), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_C", int'(C), 0);
    rst = 1'b0;

    // basic accumulate
    repeat (3) step(1, 0, 1, 0);
    repeat (2) step(1, 0, 1, 1);
    chk("acc_count", int'(dut.count), 7);
    chk("acc_C", int'(C), 0);
    chk("acc_dout", int'(dout), 0);

    // mid-drain asynchronous reset
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("pre_rst_dout", int'(dout), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_count", int'(dut.count), 0);
    chk("async_dout", int'(dout), 0);
    chk("async_C", int'(C), 0);
    mcount = 0; mc = 1'b0; md = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // overflow wrap, alternating with idle cycles
    do_reset();
    for (int i = 0; i < 8193; i++) begin
      step(1, 0, 1, 1);
      if (i == 8191) begin
`ifdef UNARY_ADD_SATURATE_EN
        chk("ovf_hit_count", int'(dut.count), 16383);
`else
        chk("ovf_hit_count", int'(dut.count), 0);
`endif
        chk("ovf_hit_C", int'(C), 1);
      end
      step(0, i[0], 1, 1);
    end
`ifdef UNARY_ADD_SATURATE_EN
    chk("ovf_count", int'(dut.count), 16383);
`else
    chk("ovf_count", int'(dut.count), 2);
`endif
    chk("ovf_C", int'(C), 1);

    // drain what's left
    ones = 0;
    repeat (20) step(1, 1, 0, 0);
`ifdef UNARY_ADD_SATURATE_EN
    chk("drain_ones", ones, 20);
    chk("drain_count", int'(dut.count), 16363);
`else
    chk("drain_ones", ones, 2);
    chk("drain_count", int'(dut.count), 0);
`endif
    chk("drain_C", int'(C), 1);

    // enable gating
    do_reset();
    repeat (5) step(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, i[0], 1, 1);
    chk("gate_count", int'(dut.count), 5);
    chk("gate_dout", int'(dout), 0);
    chk("gate_C", int'(C), 0);

    // mode interleave
    do_reset();
    repeat (2) step(1, 0, 1, 1);
    chk("il_load", int'(dut.count), 4);
    ones = 0;
    repeat (2) step(1, 1, 1, 1);
    chk("il_part_count", int'(dut.count), 2);
    chk("il_part_ones", ones, 2);
    step(1, 0, 1, 1);
    chk("il_refill", int'(dut.count), 4);
    ones = 0;
    repeat (6) step(1, 1, 0, 0);
    chk("il_ones", ones, 4);
    chk("il_count", int'(dut.count), 0);
    chk("il_dout", int'(dout), 0);

    repeat (2) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
